// File: rtl/rr_arb_mux.sv
// rr_arb_mux: registered N:1 word multiplexer with an internal arbiter.
// CHANNELS requesters present valid/data. One of them is granted, either
// round-robin (MODE=0) or by fixed lowest-index priority (MODE=1). The
// winning word is captured into a single-entry output register that drains
// through a valid/ready handshake.
module rr_arb_mux #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 32,
  parameter int SEL_BITS = 5,
  parameter int MODE     = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_BITS-1:0]       out_channel,
  input  logic                      out_ready
);

  // Round-robin pointer: the channel searched first on the next grant.
  logic [SEL_BITS-1:0] pointer;
  logic [SEL_BITS-1:0] grant_idx;
  logic                grant_found;
  logic [CHANNELS-1:0] grant;
  logic                load;
  logic                transfer;
  logic [WIDTH-1:0]    grant_word;

  // Channel index arithmetic wraps at CHANNELS rather than 2**SEL_BITS,
  // so unused index values are never produced.
  function automatic logic [SEL_BITS-1:0] wrap_index(input logic [SEL_BITS-1:0] base,
                                                     input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= CHANNELS) sum = sum - CHANNELS;
    return sum[SEL_BITS-1:0];
  endfunction

  // Arbitration: the search runs from lowest to highest priority, so the
  // last matching channel that is written is the winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    if (MODE == 1) begin
      for (int i = CHANNELS - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          grant_found = 1'b1;
          grant_idx   = i[SEL_BITS-1:0];
        end
      end
    end else begin
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        if (in_valid[wrap_index(pointer, k)]) begin
          grant_found = 1'b1;
          grant_idx   = wrap_index(pointer, k);
        end
      end
    end
  end

  // Handshake: the register can accept a word when empty or draining. The
  // grant is suppressed during reset so nothing is consumed in that cycle.
  always_comb begin
    grant = '0;
    if (grant_found) grant[grant_idx] = 1'b1;
    load       = !out_valid || out_ready;
    in_ready   = (load && !reset) ? grant : '0;
    transfer   = grant_found && load && !reset;
    grant_word = in_data[int'(grant_idx) * WIDTH +: WIDTH];
  end

  // Output register and pointer update. A load replaces the word in the
  // same edge that drains it; a drain with no load only clears valid.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_channel <= '0;
      pointer     <= '0;
    end else if (transfer) begin
      out_valid   <= 1'b1;
      out_data    <= grant_word;
      out_channel <= grant_idx;
      if (MODE == 0) pointer <= wrap_index(grant_idx, 1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed bench for rr_arb_mux. It exercises a round-robin
// 4-channel instance through a vector table, a fixed-priority instance
// through a hand-written sequence, and a 3-channel round-robin instance
// to check wrap-around at a non-power-of-two channel count.
module tb_rr_arb_mux;

  logic clock = 1'b0;

  // Free-running clock, 10 time-unit period.
  always #5 clock = ~clock;

  // Round-robin, 4 channels.
  logic        reset;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_channel;
  logic        out_ready;

  // Fixed priority, 4 channels.
  logic        p_reset;
  logic [3:0]  p_in_valid;
  logic [31:0] p_in_data;
  logic [3:0]  p_in_ready;
  logic        p_out_valid;
  logic [7:0]  p_out_data;
  logic [1:0]  p_out_channel;
  logic        p_out_ready;

  // Round-robin, 3 channels.
  logic        t_reset;
  logic [2:0]  t_in_valid;
  logic [23:0] t_in_data;
  logic [2:0]  t_in_ready;
  logic        t_out_valid;
  logic [7:0]  t_out_data;
  logic [1:0]  t_out_channel;
  logic        t_out_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  rr_arb_mux #(.WIDTH(8), .CHANNELS(4), .SEL_BITS(2), .MODE(0)) dut_rr (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_channel(out_channel), .out_ready(out_ready));

  rr_arb_mux #(.WIDTH(8), .CHANNELS(4), .SEL_BITS(2), .MODE(1)) dut_pri (
    .clock(clock), .reset(p_reset), .in_valid(p_in_valid), .in_data(p_in_data),
    .in_ready(p_in_ready), .out_valid(p_out_valid), .out_data(p_out_data),
    .out_channel(p_out_channel), .out_ready(p_out_ready));

  rr_arb_mux #(.WIDTH(8), .CHANNELS(3), .SEL_BITS(2), .MODE(0)) dut_three (
    .clock(clock), .reset(t_reset), .in_valid(t_in_valid), .in_data(t_in_data),
    .in_ready(t_in_ready), .out_valid(t_out_valid), .out_data(t_out_data),
    .out_channel(t_out_channel), .out_ready(t_out_ready));

  typedef struct {
    logic       rst;
    logic [3:0] valid;
    logic       rdy;
    logic [3:0] exp_ready;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [1:0] exp_channel;
  } vec_t;

  localparam int NUM_VECS = 26;
  vec_t vecs [NUM_VECS];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One table vector on the round-robin instance: drive after the falling
  // edge, check in_ready before the rising edge, check registers after it.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clock);
    reset     = v.rst;
    in_valid  = v.valid;
    out_ready = v.rdy;
    #1;
    checkOutput($sformatf("rr v%0d in_ready", idx), 32'(in_ready), 32'(v.exp_ready));
    @(posedge clock);
    #1;
    checkOutput($sformatf("rr v%0d out_valid", idx), 32'(out_valid), 32'(v.exp_valid));
    checkOutput($sformatf("rr v%0d out_data", idx), 32'(out_data), 32'(v.exp_data));
    checkOutput($sformatf("rr v%0d out_channel", idx), 32'(out_channel), 32'(v.exp_channel));
  endtask

  task automatic priorityStep(input int idx, input logic rst, input logic [3:0] valid,
                              input logic rdy, input logic [3:0] exp_ready,
                              input logic exp_valid, input logic [7:0] exp_data,
                              input logic [1:0] exp_channel);
    @(negedge clock);
    p_reset     = rst;
    p_in_valid  = valid;
    p_out_ready = rdy;
    #1;
    checkOutput($sformatf("pri s%0d in_ready", idx), 32'(p_in_ready), 32'(exp_ready));
    @(posedge clock);
    #1;
    checkOutput($sformatf("pri s%0d out_valid", idx), 32'(p_out_valid), 32'(exp_valid));
    checkOutput($sformatf("pri s%0d out_data", idx), 32'(p_out_data), 32'(exp_data));
    checkOutput($sformatf("pri s%0d out_channel", idx), 32'(p_out_channel), 32'(exp_channel));
  endtask

  initial begin
    // rst, valid, rdy, exp_ready, exp_valid, exp_data, exp_channel
    // Reset with every channel requesting.
    vecs[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
    vecs[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
    // Fairness: eight transfers cycle 0,1,2,3 twice.
    vecs[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h00, 2'd0};
    vecs[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd2};
    vecs[5]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd3};
    vecs[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h00, 2'd0};
    vecs[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd2};
    vecs[9]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd3};
    // Sparse: grant 2 (pointer -> 3), then only 1 requests: wraps to 1.
    vecs[10] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd2};
    vecs[11] = '{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    // Drain with no request, then idle: data and channel hold.
    vecs[12] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1};
    vecs[13] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h11, 2'd1};
    // Empty register loads channel 2 even without out_ready, then stalls.
    vecs[14] = '{1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 8'h22, 2'd2};
    vecs[15] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd2};
    vecs[16] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd2};
    vecs[17] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd2};
    // Release: channel 3 loads on the draining edge (pointer was frozen).
    vecs[18] = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd3};
    vecs[19] = '{1'b0, 4'b1110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[20] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1};
    // Reset mid-stall clears the register and the pointer.
    vecs[21] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0};
    vecs[22] = '{1'b0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    // Reset while a load would occur: no in_ready, word discarded.
    vecs[23] = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
    vecs[24] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 8'h00, 2'd0};
    vecs[25] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};

    reset       = 1'b1;
    in_valid    = '0;
    in_data     = 32'h33221100;
    out_ready   = 1'b0;
    p_reset     = 1'b1;
    p_in_valid  = '0;
    p_in_data   = 32'h33221100;
    p_out_ready = 1'b0;
    t_reset     = 1'b1;
    t_in_valid  = '0;
    t_in_data   = 24'h221100;
    t_out_ready = 1'b0;

    for (int i = 0; i < NUM_VECS; i++) applyStimulus(vecs[i], i);

    // Fixed priority: lowest index always wins; channel 3 starves.
    priorityStep(0, 1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);
    priorityStep(1, 1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0);
    priorityStep(2, 1'b0, 4'b1100, 1'b1, 4'b0100, 1'b1, 8'h22, 2'd2);
    priorityStep(3, 1'b0, 4'b1101, 1'b1, 4'b0001, 1'b1, 8'h00, 2'd0);
    priorityStep(4, 1'b0, 4'b1101, 1'b1, 4'b0001, 1'b1, 8'h00, 2'd0);
    priorityStep(5, 1'b0, 4'b1000, 1'b1, 4'b1000, 1'b1, 8'h33, 2'd3);
    priorityStep(6, 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, 8'h33, 2'd3);
    priorityStep(7, 1'b0, 4'b0110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1);
    priorityStep(8, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd1);

    // Three channels: grants wrap 2 -> 0, never reaching index 3.
    @(negedge clock);
    t_reset     = 1'b1;
    t_in_valid  = 3'b111;
    t_out_ready = 1'b1;
    @(negedge clock);
    t_reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      logic [2:0] exp_ready;
      exp_ready = 3'b001 << (i % 3);
      #1;
      checkOutput($sformatf("three s%0d in_ready", i), 32'(t_in_ready), 32'(exp_ready));
      @(posedge clock);
      #1;
      checkOutput($sformatf("three s%0d out_channel", i), 32'(t_out_channel), 32'(i % 3));
      checkOutput($sformatf("three s%0d out_data", i), 32'(t_out_data), 32'((i % 3) * 8'h11));
      @(negedge clock);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Registered, arbitrating N:1 word multiplexer and parametrised successor of the fixed 32:1 select mux.
- Instead of an externally driven select, CHANNELS requesters present valid/data, and an internal arbiter picks one.
- The winning word is captured into a single-entry output register with a valid/ready handshake.
- Used wherever several processor sources (writeback ports, MMIO, debug) share one datapath without a combinational select path.

Parameters:
WIDTH, 32, data word width in bits (>=1)
CHANNELS, 32, number of input channels (2..32)
SEL_BITS, 5, width of channel index; must satisfy 2**SEL_BITS >= CHANNELS
MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority (lowest index wins)

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  CHANNELS  bit i set: channel i presents a word
in_data  input  CHANNELS*WIDTH  channel i word at bits [i*WIDTH +: WIDTH]
in_ready  output  CHANNELS  one-hot (or zero); bit i set: channel i word is consumed this cycle
out_valid  output  1  output register holds a word
out_data  output  WIDTH  registered selected word
out_channel  output  SEL_BITS  index of the channel that supplied out_data
out_ready  input  1  downstream accepts out_data this cycle

Behaviour:
- Reset (synchronous, active-high, wins over all other activity):
  - out_valid=0, out_data=0, out_channel=0, rr pointer=0.
  - in_ready=0 for the whole reset cycle.
  - Reset asserted mid-transfer discards the held word; no in_ready is issued that cycle.
- load = !out_valid || out_ready. The register is free, or is being drained this same cycle.
- Grant is combinational from in_valid and the pointer.
  - MODE=0: the first valid channel at or after pointer, searching upward and wrapping CHANNELS-1 -> 0.
  - MODE=1: the lowest-index valid channel; pointer is ignored.
- in_ready[i] = load && grant[i] && !reset. At most one bit is set. If no in_valid is set, in_ready=0.
- Transfer on a channel occurs when in_valid[i] && in_ready[i]. At that edge:
  - out_data <= word of channel i, out_channel <= i, out_valid <= 1.
  - MODE=0: pointer <= (i+1) mod CHANNELS. This is wrap-around, not a 2**SEL_BITS wrap.
- Output drain: out_valid && out_ready with no new grant -> out_valid <= 0. out_data and out_channel hold their last value.
- Simultaneous drain and load: the register is replaced in the same edge, giving full throughput of one word per cycle.
- Stall: while out_valid && !out_ready, out_data and out_channel are stable, all in_ready=0, and the pointer is frozen.
- Latency: a word accepted at edge k is visible on out_data at edge k (registered output), one cycle after presentation.
- Pointer advances only on a transfer. Idle cycles do not move it.
- Fairness (MODE=0): under continuous requests from all channels, each channel is granted exactly once per CHANNELS transfers.
- in_valid and in_data may change freely when in_ready is low. No combinational path from out_ready to out_data.
- CHANNELS not a power of two: unused index values are never produced on out_channel.

Test Plan:
1. Reset then idle: reset=1 for 2 cycles with in_valid=all ones -> in_ready=0, out_valid=0, out_data=0, out_channel=0. After release, with out_ready=1, the first grant is channel 0.
2. Round-robin fairness: MODE=0, CHANNELS=4, WIDTH=8, in_data={8'h33,8'h22,8'h11,8'h00}, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_channel sequence 0,1,2,3,0,1,2,3 and out_data 00,11,22,33 repeating. out_valid stays 1 throughout.
3. Sparse requests and wrap: MODE=0, CHANNELS=4, pointer at 3 after channel 2 granted. in_valid=4'b0010 -> grant channel 1 (wrap past 3,0). Pointer becomes 2.
4. Backpressure: out_valid=1 with out_data=8'h22, out_ready=0 for 3 cycles while in_valid=4'b1111 -> out_data holds 8'h22, in_ready=0, pointer unchanged. out_ready=1 -> the next channel is loaded the same edge with no bubble.
5. Fixed priority: MODE=1, in_valid=4'b1100 then 4'b1101 -> grants channel 2, then channel 0. Channel 3 is starved while lower channels request.
6. Reset mid-stall: out_valid=1, out_ready=0, reset=1 for one cycle -> next cycle out_valid=0, out_data=0, and the pointer returns to 0.
